// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes over a 128-bit state, LANES bytes per cycle through per-lane inverse S-box ROMs.
// Latency NCYC=16/LANES cycles from acceptance to out_valid; holds result in DONE until out_ready.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0][7:0] st, st_sub;
  logic [CW-1:0]    cnt;
  logic             load;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    case (x)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

  // in_ready depends combinationally on out_ready so a finished block can hand off in the same edge.
  assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign load      = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = st;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte 0 sits in the top lane of st (st[15]), so byte b lives at index 15-b.
  always_comb begin
    st_sub = st;
    for (int l = 0; l < LANES; l++) begin
      st_sub[4'(15 - (int'(cnt) * LANES + l))] = inv_sbox(st[4'(15 - (int'(cnt) * LANES + l))]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= '0;
      cnt <= '0;
    end else if (load) begin
      st  <= in_state;
      cnt <= '0;
    end else if (state == RUN) begin
      st <= st_sub;
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: main instance LANES=4 plus LANES 1/2/8/16 for ROM corners and latency.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;

  logic [3:0]   x_in_ready, x_out_valid, x_busy;
  logic [127:0] x_out_state [4];

  int checks = 0;
  int failures = 0;

  localparam int XN [4] = '{16, 8, 2, 1};

  // Reference inverse S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] ISB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  localparam logic [127:0] TV_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] TV_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

  inv_sub_bytes_seq #(.LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy));

  for (genvar g = 0; g < 4; g++) begin : gx
    inv_sub_bytes_seq #(.LANES((g < 2) ? (1 << g) : (1 << (g + 1)))) u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready[g]), .in_state(in_state),
      .out_valid(x_out_valid[g]), .out_ready(out_ready), .out_state(x_out_state[g]), .busy(x_busy[g]));
  end

  always #5 clk = ~clk;

  function automatic logic [127:0] model(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = ISB[2047 - 8*int'(x[127-8*i -: 8]) -: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input int max, output int lat);
    lat = 0;
    while (!out_valid && lat < max) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Accept one block on every instance, then record first out_valid cycle and data for each.
  task automatic send_all(input logic [127:0] d, input logic [127:0] e, input string tag);
    int ml;
    logic [127:0] md;
    int xl [4];
    logic [127:0] xd [4];
    ml = -1; md = '0;
    for (int g = 0; g < 4; g++) begin xl[g] = -1; xd[g] = '0; end
    in_state = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid && ml < 0) begin ml = k; md = out_state; end
      for (int g = 0; g < 4; g++)
        if (x_out_valid[g] && xl[g] < 0) begin xl[g] = k; xd[g] = x_out_state[g]; end
    end
    chk($sformatf("%s_lat_l4", tag), 128'(ml), 128'(4));
    chk($sformatf("%s_dat_l4", tag), md, e);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_lat_ncyc%0d", tag, XN[g]), 128'(xl[g]), 128'(XN[g]));
      chk($sformatf("%s_dat_ncyc%0d", tag, XN[g]), xd[g], e);
    end
  endtask

  initial begin
    int lat, ai, oi, last, cyc;
    logic acc;
    logic [127:0] blk [8];
    logic [127:0] a_exp;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_in_ready_low", 128'(in_ready), 128'(0));
    rst_n = 1'b1; #1;
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    // Known-answer vector and ROM corners across all lane counts
    send_all(TV_IN, TV_OUT, "kat");
    send_all({16{8'h00}}, {16{8'h52}}, "all00");
    send_all({16{8'h63}}, {16{8'h00}}, "all63");
    send_all({16{8'hff}}, {16{8'h7d}}, "allff");

    // Backpressure: hold DONE with a competing input present
    out_ready = 1'b0;
    in_state = TV_IN; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(40, lat);
    chk("bp_lat", 128'(lat), 128'(4));
    in_state = {16{8'h00}}; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_state}, {1'b1, 1'b0, TV_OUT});
    end
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_captured", {busy, out_valid}, {1'b1, 1'b0});
    wait_out(40, lat);
    chk("bp2_lat", 128'(lat), 128'(4));
    chk("bp2_dat", out_state, {16{8'h52}});
    repeat (20) @(posedge clk);
    #1;

    // Streaming: back-to-back random blocks
    for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    ai = 0; oi = 0; last = -1; cyc = 0;
    in_state = blk[0]; in_valid = 1'b1;
    while (oi < 8 && cyc < 200) begin
      if (out_valid) begin
        chk($sformatf("stream_dat%0d", oi), out_state, model(blk[oi]));
        if (oi > 0) chk($sformatf("stream_gap%0d", oi), 128'(cyc - last), 128'(5));
        last = cyc;
        oi++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        ai++;
        if (ai < 8) in_state = blk[ai];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", 128'(oi), 128'(8));
    repeat (20) @(posedge clk);
    #1;

    // Input activity during RUN is ignored
    in_state = TV_IN; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("run_in_ready%0d", i), 128'(in_ready), 128'(0));
      in_valid = (i < 3) ? ~in_valid : 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    chk("run_ignore_done", 128'(out_valid), 128'(1));
    chk("run_ignore_dat", out_state, TV_OUT);
    @(posedge clk); #1;

    // Reset in the middle of a block
    a_exp = {16{8'h7d}};
    in_state = {16{8'hff}}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_state", {out_valid, busy, in_ready, out_state}, {3'b000, 128'h0});
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst_quiet%0d", i), {out_valid, busy}, 2'b00);
    end
    in_state = {16{8'hff}}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(40, lat);
    chk("post_rst_lat", 128'(lat), 128'(4));
    chk("post_rst_dat", out_state, a_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
